// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into SEG
// segments with one register stage per segment. A single global advance
// moves the whole pipeline, so bubbles travel through it unchanged.
module pipelined_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SW = WIDTH / SEG;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin0;

  // Whole pipeline moves when the output register is empty or being drained
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // Subtraction is a + ~b + 1; the external carry-in is ignored then
  assign b_eff = sub ? ~b : b;
  assign cin0  = sub | cin;

  // Stage k adds segment k; its inputs hold only the not-yet-added upper
  // operand bits plus the lower sum bits already produced.
  for (genvar k = 0; k < SEG; k++) begin : stg
    localparam int unsigned RW = WIDTH - k * SW;
    localparam int unsigned LW = k * SW;

    logic [RW-1:0]    a_in;
    logic [RW-1:0]    b_in;
    logic             c_in;
    logic             v_in;
    logic [SW:0]      seg;
    logic [LW+SW-1:0] s_out;

    if (k == 0) begin : g_first
      assign a_in  = a;
      assign b_in  = b_eff;
      assign c_in  = cin0;
      assign v_in  = in_valid;
      assign s_out = seg[SW-1:0];
    end else begin : g_mid
      logic [RW-1:0] a_r;
      logic [RW-1:0] b_r;
      logic [LW-1:0] s_r;
      logic          c_r;
      logic          v_r;

      // Stage valid bit: cleared by reset, shifts only on advance
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_r <= 1'b0;
        end else if (adv) begin
          v_r <= stg[k-1].v_in;
        end
      end

      // Stage data: remaining operands, segment carry and partial sum
      always_ff @(posedge clk) begin
        if (adv) begin
          a_r <= stg[k-1].a_in[RW+SW-1:SW];
          b_r <= stg[k-1].b_in[RW+SW-1:SW];
          s_r <= stg[k-1].s_out;
          c_r <= stg[k-1].seg[SW];
        end
      end

      assign a_in  = a_r;
      assign b_in  = b_r;
      assign c_in  = c_r;
      assign v_in  = v_r;
      assign s_out = {seg[SW-1:0], s_r};
    end

    // Segment adder with carry out in the top bit
    assign seg = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + (SW+1)'(c_in);
  end

  logic msb_cin;
  logic ovf_nxt;

  // Carry into the MSB recovered from the MSB sum bit and its operand bits
  assign msb_cin = stg[SEG-1].a_in[SW-1] ^ stg[SEG-1].b_in[SW-1] ^ stg[SEG-1].seg[SW-1];
  assign ovf_nxt = stg[SEG-1].seg[SW] ^ msb_cin;

  // Output register bank: result, flags and valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= stg[SEG-1].v_in;
      sum       <= stg[SEG-1].s_out;
      cout      <= stg[SEG-1].seg[SW];
      ovf       <= ovf_nxt;
    end
  end

endmodule
